// File: rtl/pipe_stage_reg_pkg.sv
// Shared state encodings and widths for the pipeline-boundary register.
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        PIPE_ST_EMPTY = 2'd0,
        PIPE_ST_ONE   = 2'd1,
        PIPE_ST_TWO   = 2'd2
    } pipe_state_e;

    localparam int PIPE_PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter; sticks at all-ones and clears only on rst.
module pipe_perf_cnt
    import pipe_stage_reg_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inc_i,
    output logic [PIPE_PERF_CNT_W-1:0] cnt_o
);

    logic [PIPE_PERF_CNT_W-1:0] cnt_q;
    logic [PIPE_PERF_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline-boundary register: valid/ready with 2-entry skid, flush and sticky sideband.
// Define PIPE_STAGE_PERF_EN to build the stall/bubble performance counters.
//
// state | meaning
// EMPTY | no payload held, dn_valid=0, up_ready=1
// ONE   | main holds payload, dn_valid=1, up_ready=1
// TWO   | main and skid hold payloads, dn_valid=1, up_ready=0
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SIDE_W        = 1,
    parameter int ZERO_ON_EMPTY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [DATA_W-1:0]          up_data,
    input  logic [SIDE_W-1:0]          up_side,
    output logic                       dn_valid,
    input  logic                       dn_ready,
    output logic [DATA_W-1:0]          dn_data,
    output logic [SIDE_W-1:0]          dn_side,
    output logic [PIPE_PERF_CNT_W-1:0] perf_stall_cnt,
    output logic [PIPE_PERF_CNT_W-1:0] perf_bubble_cnt
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [SIDE_W-1:0] side_q, side_d;
    logic [SIDE_W-1:0] side_skid_q, side_skid_d;
    logic [DATA_W-1:0] main_empty;
    logic [DATA_W-1:0] skid_empty;

    assign main_empty = (ZERO_ON_EMPTY != 0) ? '0 : main_q;
    assign skid_empty = (ZERO_ON_EMPTY != 0) ? '0 : skid_q;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        side_d      = side_q;
        side_skid_d = side_skid_q;
        if (flush) begin
            state_d     = PIPE_ST_EMPTY;
            main_d      = main_empty;
            skid_d      = skid_empty;
            side_d      = '0;
            side_skid_d = '0;
        end else begin
            case (state_q)
                PIPE_ST_EMPTY: begin
                    if (up_valid) begin
                        state_d = PIPE_ST_ONE;
                        main_d  = up_data;
                        side_d  = up_side;
                    end
                end
                PIPE_ST_ONE: begin
                    if (dn_ready && up_valid) begin
                        main_d = up_data;
                        side_d = up_side;
                    end else if (dn_ready) begin
                        // side_q is left alone so the sideband stays sticky across the bubble
                        state_d = PIPE_ST_EMPTY;
                        main_d  = main_empty;
                    end else if (up_valid) begin
                        state_d     = PIPE_ST_TWO;
                        skid_d      = up_data;
                        side_skid_d = up_side;
                    end
                end
                PIPE_ST_TWO: begin
                    if (dn_ready) begin
                        state_d = PIPE_ST_ONE;
                        main_d  = skid_q;
                        side_d  = side_skid_q;
                    end
                end
                default: begin
                    state_d = PIPE_ST_EMPTY;
                    main_d  = main_empty;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PIPE_ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            side_q      <= '0;
            side_skid_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            side_q      <= side_d;
            side_skid_q <= side_skid_d;
        end
    end

    assign up_ready = (state_q != PIPE_ST_TWO);
    assign dn_valid = (state_q != PIPE_ST_EMPTY);
    assign dn_data  = main_q;
    assign dn_side  = side_q;

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (dn_valid && !dn_ready),
        .cnt_o (perf_stall_cnt)
    );

    pipe_perf_cnt u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (!dn_valid),
        .cnt_o (perf_bubble_cnt)
    );
`else
    assign perf_stall_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
// Honours PIPE_STAGE_PERF_EN for the performance-counter checks.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst, flush, up_valid, dn_ready;
    logic        up_ready, dn_valid;
    logic [31:0] up_data, dn_data;
    logic [0:0]  up_side, dn_side;
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;

    int total = 0;
    int bad   = 0;

    pipe_stage_reg #(.DATA_W(32), .SIDE_W(1), .ZERO_ON_EMPTY(1)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .up_valid        (up_valid),
        .up_ready        (up_ready),
        .up_data         (up_data),
        .up_side         (up_side),
        .dn_valid        (dn_valid),
        .dn_ready        (dn_ready),
        .dn_data         (dn_data),
        .dn_side         (dn_side),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
    );

    always #5 clk = ~clk;

    // Model: the stage is a FIFO of at most two entries whose accept decision
    // depends only on the occupancy before the edge.
    typedef struct packed {
        logic [31:0] d;
        logic [0:0]  s;
    } ent_t;

    ent_t        mq[$];
    logic [0:0]  sticky = 1'b0;
    logic [31:0] stall_m = '0, bubble_m = '0;
    logic        exp_valid, exp_ready;
    logic [31:0] exp_data, exp_stall, exp_bubble;
    logic [0:0]  exp_side;

    task automatic cycle(input logic r, input logic f, input logic uv,
                         input logic [31:0] ud, input logic [0:0] us, input logic dr);
        bit push, pop;
        rst = r; flush = f; up_valid = uv; up_data = ud; up_side = us; dn_ready = dr;
        @(posedge clk);
        push = uv && (mq.size() < 2);
        pop  = (mq.size() > 0) && dr;
        if (r) begin
            stall_m = '0; bubble_m = '0;
        end else begin
            if (mq.size() > 0 && !dr && stall_m != 32'hFFFF_FFFF) stall_m++;
            if (mq.size() == 0 && bubble_m != 32'hFFFF_FFFF) bubble_m++;
        end
        if (r || f) begin
            mq.delete();
            sticky = 1'b0;
        end else begin
            if (pop) begin
                sticky = mq[0].s;
                void'(mq.pop_front());
            end
            if (push) mq.push_back('{d: ud, s: us});
        end
        #1;
        exp_valid = (mq.size() > 0);
        exp_ready = (mq.size() < 2);
        exp_data  = exp_valid ? mq[0].d : 32'h0;
        exp_side  = exp_valid ? mq[0].s : sticky;
`ifdef PIPE_STAGE_PERF_EN
        exp_stall  = stall_m;
        exp_bubble = bubble_m;
`else
        exp_stall  = '0;
        exp_bubble = '0;
`endif
    endtask

    task automatic test_reset();
        cycle(1, 0, 0, 32'h0, 1'b0, 0);
        cycle(1, 0, 1, 32'hFFFF_FFFF, 1'b1, 1);
        total++; if (dn_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", dn_valid); end
        total++; if (up_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", up_ready); end
        total++; if (dn_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", dn_data); end
        total++; if (dn_side !== 1'b0) begin bad++; $display("FAIL reset_side got=%0b exp=0", dn_side); end
        total++; if (perf_stall_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin
            bad++; $display("FAIL reset_perf got=%h/%h exp=0/0", perf_stall_cnt, perf_bubble_cnt);
        end
    endtask

    task automatic test_stream();
        logic [31:0] w;
        cycle(0, 0, 1, 32'h1234_5678, 1'b0, 1);
        total++; if (dn_valid !== 1'b1 || dn_data !== 32'h1234_5678) begin
            bad++; $display("FAIL first_word got=%0b/%h exp=1/12345678", dn_valid, dn_data);
        end
        for (int i = 0; i < 8; i++) begin
            w = 32'hC0DE_0000 + i;
            cycle(0, 0, 1, w, 1'b0, 1);
            total++; if (dn_valid !== 1'b1 || dn_data !== w || up_ready !== 1'b1) begin
                bad++; $display("FAIL stream_%0d got=%0b/%h/%0b exp=1/%h/1", i, dn_valid, dn_data, up_ready, w);
            end
        end
        cycle(0, 0, 0, 32'h0, 1'b0, 1);
        total++; if (dn_valid !== 1'b0 || dn_data !== 32'h0) begin
            bad++; $display("FAIL stream_drain got=%0b/%h exp=0/0", dn_valid, dn_data);
        end
    endtask

    task automatic test_skid();
        cycle(1, 0, 0, 32'h0, 1'b0, 0);
        cycle(0, 0, 1, 32'hA, 1'b0, 0);
        cycle(0, 0, 1, 32'hB, 1'b0, 0);
        total++; if (up_ready !== 1'b0 || dn_data !== 32'hA || dn_valid !== 1'b1) begin
            bad++; $display("FAIL skid_two got=%0b/%h/%0b exp=0/0000000a/1", up_ready, dn_data, dn_valid);
        end
        cycle(0, 0, 1, 32'hC, 1'b0, 0);
        total++; if (up_ready !== 1'b0 || dn_data !== 32'hA) begin
            bad++; $display("FAIL skid_hold got=%0b/%h exp=0/0000000a", up_ready, dn_data);
        end
        cycle(0, 0, 0, 32'h0, 1'b0, 1);
        total++; if (dn_data !== 32'hB || up_ready !== 1'b1 || dn_valid !== 1'b1) begin
            bad++; $display("FAIL skid_pop_a got=%h/%0b/%0b exp=0000000b/1/1", dn_data, up_ready, dn_valid);
        end
        cycle(0, 0, 0, 32'h0, 1'b0, 1);
        total++; if (dn_valid !== 1'b0 || dn_data !== 32'h0) begin
            bad++; $display("FAIL skid_pop_b got=%0b/%h exp=0/0", dn_valid, dn_data);
        end
    endtask

    task automatic test_sticky_side();
        cycle(1, 0, 0, 32'h0, 1'b0, 0);
        cycle(0, 0, 1, 32'h55, 1'b1, 0);
        cycle(0, 0, 0, 32'h0, 1'b0, 1);
        total++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || dn_side !== 1'b1) begin
            bad++; $display("FAIL sticky_drain got=%0b/%h/%0b exp=0/0/1", dn_valid, dn_data, dn_side);
        end
        cycle(0, 0, 0, 32'h0, 1'b0, 1);
        cycle(0, 0, 0, 32'h0, 1'b0, 0);
        total++; if (dn_side !== 1'b1) begin bad++; $display("FAIL sticky_hold got=%0b exp=1", dn_side); end
    endtask

    task automatic test_flush();
        cycle(1, 0, 0, 32'h0, 1'b0, 0);
        cycle(0, 0, 1, 32'h1, 1'b1, 0);
        cycle(0, 0, 1, 32'h2, 1'b1, 0);
        cycle(0, 1, 1, 32'hDEAD_BEEF, 1'b1, 0);
        total++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || dn_side !== 1'b0 || up_ready !== 1'b1) begin
            bad++; $display("FAIL flush_two got=%0b/%h/%0b/%0b exp=0/0/0/1", dn_valid, dn_data, dn_side, up_ready);
        end
        cycle(0, 0, 0, 32'h0, 1'b0, 1);
        total++; if (dn_valid !== 1'b0 || dn_data !== 32'h0) begin
            bad++; $display("FAIL flush_discard got=%0b/%h exp=0/0", dn_valid, dn_data);
        end
    endtask

    task automatic test_rst_mid();
        cycle(0, 0, 1, 32'h11, 1'b1, 0);
        cycle(0, 0, 1, 32'h22, 1'b1, 0);
        cycle(1, 0, 1, 32'h33, 1'b1, 1);
        total++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || dn_side !== 1'b0 || up_ready !== 1'b1) begin
            bad++; $display("FAIL rst_two got=%0b/%h/%0b/%0b exp=0/0/0/1", dn_valid, dn_data, dn_side, up_ready);
        end
        cycle(0, 0, 1, 32'h44, 1'b1, 0);
        cycle(1, 1, 1, 32'h55, 1'b1, 0);
        total++; if (dn_valid !== 1'b0 || dn_data !== 32'h0 || dn_side !== 1'b0 || up_ready !== 1'b1 ||
                     perf_stall_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin
            bad++; $display("FAIL rst_flush got=%0b/%h/%0b/%0b/%h/%h exp=0/0/0/1/0/0",
                            dn_valid, dn_data, dn_side, up_ready, perf_stall_cnt, perf_bubble_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(63) == 0), ($urandom_range(15) == 0), 1'($urandom_range(1)),
                  $urandom, 1'($urandom_range(1)), ($urandom_range(3) != 0));
            total++;
            if (dn_valid !== exp_valid || up_ready !== exp_ready || dn_data !== exp_data ||
                dn_side !== exp_side || perf_stall_cnt !== exp_stall || perf_bubble_cnt !== exp_bubble) begin
                bad++;
                $display("FAIL random_%0d got=%0b/%0b/%h/%0b/%h/%h exp=%0b/%0b/%h/%0b/%h/%h", i,
                         dn_valid, up_ready, dn_data, dn_side, perf_stall_cnt, perf_bubble_cnt,
                         exp_valid, exp_ready, exp_data, exp_side, exp_stall, exp_bubble);
            end
        end
    endtask

    task automatic test_perf();
`ifdef PIPE_STAGE_PERF_EN
        cycle(1, 0, 0, 32'h0, 1'b0, 0);
        cycle(0, 0, 1, 32'h7, 1'b0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 32'h0, 1'b0, 0);
        cycle(0, 0, 0, 32'h0, 1'b0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 1'b0, 0);
        total++; if (perf_stall_cnt !== 32'd5 || perf_bubble_cnt !== 32'd4) begin
            bad++; $display("FAIL perf_count got=%0d/%0d exp=5/4", perf_stall_cnt, perf_bubble_cnt);
        end
        cycle(0, 1, 0, 32'h0, 1'b0, 0);
        total++; if (perf_stall_cnt !== 32'd5 || perf_bubble_cnt !== 32'd5) begin
            bad++; $display("FAIL perf_flush got=%0d/%0d exp=5/5", perf_stall_cnt, perf_bubble_cnt);
        end
        force u_dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
        #1;
        release u_dut.u_stall_cnt.cnt_q;
        cycle(0, 0, 1, 32'h9, 1'b0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 32'h0, 1'b0, 0);
        total++; if (perf_stall_cnt !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL perf_sat got=%h exp=ffffffff", perf_stall_cnt);
        end
`else
        cycle(0, 0, 1, 32'h7, 1'b0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 32'h0, 1'b0, 0);
        total++; if (perf_stall_cnt !== 32'h0 || perf_bubble_cnt !== 32'h0) begin
            bad++; $display("FAIL perf_tied got=%h/%h exp=0/0", perf_stall_cnt, perf_bubble_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0;
        up_data = '0; up_side = '0;
        test_reset();
        test_stream();
        test_skid();
        test_sticky_side();
        test_flush();
        test_rst_mid();
        test_random();
        test_perf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
